// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA pixel fetch block.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    // One 24-bit pixel, packed so it maps directly onto {r,g,b} memory words.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD
    } fetch_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous pixel FIFO with occupancy count and flush.
// Head entry is read combinationally so the consumer can register it on pop.
module pixel_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  pixel_t                   push_data,
    input  logic                     pop,
    output pixel_t                   pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    pixel_t             mem [DEPTH];
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [AW:0]        count_reg;
    logic               do_push;
    logic               do_pop;

    // A push into a full FIFO or a pop from an empty one is ignored.
    assign do_push  = push && !flush && (count_reg != AW'(0) + (AW+1)'(DEPTH));
    assign do_pop   = pop && !flush && (count_reg != '0);
    assign pop_data = mem[rd_ptr_reg];
    assign count    = count_reg;
    assign empty    = (count_reg == '0);

    // Storage array; write only, no reset needed.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers and occupancy; flush empties without touching storage.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Prefetches frame pixels from memory into a FIFO and feeds them to the
// VGA output stage one per pixel-enable during the visible region.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 19
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              pix_en,
    input  logic              active,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [23:0]       mem_data,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              underflow
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    // Fetch address is one bit wider so it can hold the saturated frame end
    // even when the frame size is an exact power of two.
    localparam logic [ADDR_W:0]  FRAME_END  = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);
    localparam logic [CNT_W-1:0] FILL_LIMIT = CNT_W'(FIFO_DEPTH - 1);

    fetch_state_t       state_reg;
    logic [ADDR_W:0]    fetch_addr_reg;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    pixel_t             fifo_head;
    logic               push;
    logic               pop;

    // Acks are accepted only while a request is open; frame_start discards them.
    assign push = (state_reg == ST_REQ) && mem_ack && !frame_start;
    assign pop  = pix_en && active && !fifo_empty && !frame_start;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .flush     (frame_start),
        .push      (push),
        .push_data (pixel_t'(mem_data)),
        .pop       (pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // Fetch FSM: one outstanding request, one slot kept free for its ack.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            mem_req        <= 1'b0;
            mem_addr       <= '0;
            fetch_addr_reg <= '0;
        end else if (frame_start) begin
            state_reg      <= ST_IDLE;
            mem_req        <= 1'b0;
            mem_addr       <= '0;
            fetch_addr_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if ((fifo_count < FILL_LIMIT) && (fetch_addr_reg < FRAME_END)) begin
                        state_reg <= ST_REQ;
                        mem_req   <= 1'b1;
                        mem_addr  <= fetch_addr_reg[ADDR_W-1:0];
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        state_reg      <= ST_HOLD;
                        mem_req        <= 1'b0;
                        fetch_addr_reg <= fetch_addr_reg + 1'b1;
                    end
                end
                ST_HOLD: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    mem_req   <= 1'b0;
                end
            endcase
        end
    end

    // Output register: pixel on pop, black when blanked or starved, hold otherwise.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r         <= '0;
            g         <= '0;
            b         <= '0;
            underflow <= 1'b0;
        end else begin
            if (pix_en && !frame_start) begin
                if (pop) begin
                    r <= fifo_head.r;
                    g <= fifo_head.g;
                    b <= fifo_head.b;
                end else begin
                    r <= '0;
                    g <= '0;
                    b <= '0;
                end
            end
            if (frame_start) begin
                underflow <= 1'b0;
            end else if (pix_en && active && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench for vga_pixel_fetch on a reduced 16x4 frame.
// Memory returns data equal to the address, so the k-th visible pixel of a
// frame must carry value k whenever the memory side has delivered it.
module tb_vga_pixel_fetch;
    import vga_pkg::*;

    localparam int H     = 16;
    localparam int V     = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 8;
    localparam int FRAME = H * V;

    logic          clk_in      = 1'b0;
    logic          rst_n       = 1'b0;
    logic          frame_start = 1'b0;
    logic          pix_en      = 1'b0;
    logic          active      = 1'b0;
    logic          mem_ack     = 1'b0;
    logic [23:0]   mem_data    = '0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [7:0]    r;
    logic [7:0]    g;
    logic [7:0]    b;
    logic          underflow;

    always #5 clk_in = ~clk_in;

    vga_pixel_fetch #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (AW)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pix_en      (pix_en),
        .active      (active),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .r           (r),
        .g           (g),
        .b           (b),
        .underflow   (underflow)
    );

    typedef struct {
        logic [23:0] rgb;
        logic        uf;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          pushed   = 0;   // pixels the memory side has delivered this frame
    int          consumed = 0;   // visible pixels that received real data
    int          wait_cnt = 0;
    int          delay    = 0;
    logic        uf_m     = 1'b0;
    logic [23:0] last_rgb = '0;
    logic        fs_done  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // One clock: compare last cycle's outputs, model memory, drive next inputs.
    task automatic cycle(input logic fs_in, input logic fs_if_req, input logic pe, input logic act);
        exp_t e;
        logic ack;
        logic fs;
        @(negedge clk_in);
        if (q.size() != 0) begin
            e = q.pop_front();
            check_eq("rgb", 32'({r, g, b}), 32'(e.rgb));
            check_eq("underflow", 32'(underflow), 32'(e.uf));
        end
        if (mem_req) begin
            check_eq("addr_in_frame", 32'(mem_addr < FRAME), 32'd1);
        end
        fs  = fs_in | (fs_if_req & mem_req);
        ack = 1'b0;
        if (mem_req) begin
            if (wait_cnt >= delay) begin
                ack      = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        if (ack) begin
            check_eq("fetch_addr", 32'(mem_addr), 32'(pushed));
            $display("mem ack addr=%0d fs=%0d", mem_addr, fs);
        end
        mem_ack  = ack;
        mem_data = 24'(mem_addr);
        if (fs) begin
            uf_m     = 1'b0;
            pushed   = 0;
            consumed = 0;
            fs_done  = 1'b1;
        end else begin
            if (pe) begin
                if (act) begin
                    if (pushed > consumed) begin
                        last_rgb = 24'(consumed);
                        consumed++;
                    end else begin
                        last_rgb = '0;
                        uf_m     = 1'b1;
                    end
                end else begin
                    last_rgb = '0;
                end
            end
            if (ack) pushed++;
        end
        q.push_back('{rgb: last_rgb, uf: uf_m});
        frame_start = fs;
        pix_en      = fs ? 1'b0 : pe;
        active      = act;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int npix;
        logic pe;

        // Reset values
        repeat (3) @(negedge clk_in);
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_rgb", 32'({r, g, b}), 32'd0);
        check_eq("rst_uf", 32'(underflow), 32'd0);
        rst_n = 1'b1;

        // Fill with no consumption: stops at DEPTH-1 entries
        delay = 1;
        for (int i = 0; i < 80; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("fill_count", 32'(pushed), 32'(DEPTH - 1));
        check_eq("fill_idle", 32'(mem_req), 32'd0);

        // Steady stream, pix_en every 4th cycle with blanking gaps
        delay = 0;
        for (int i = 0; i < 200; i++) cycle(1'b0, 1'b0, (i % 4) == 0, ((i / 4) % 20) < 16);
        check_eq("stream_uf", 32'(underflow), 32'd0);

        // Slow memory, consume every cycle: starvation
        delay = 20;
        for (int i = 0; i < 60; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("starve_uf", 32'(underflow), 32'd1);

        // frame_start while a request is open
        fs_done = 1'b0;
        for (int i = 0; i < 100 && !fs_done; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("fs_seen", 32'(fs_done), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("fs_req_drop", 32'(mem_req), 32'd0);
        check_eq("fs_uf_clear", 32'(underflow), 32'd0);
        delay = 0;
        cycle(1'b0, 1'b0, 1'b1, 1'b1);   // flushed FIFO: black + underflow

        // Full frame followed by extra visible pixels
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        npix = 0;
        for (int i = 0; i < 2000 && npix < FRAME + 8; i++) begin
            pe = ((i % 4) == 0);
            if (pe) npix++;
            cycle(1'b0, 1'b0, pe, 1'b1);
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("frame_total", 32'(pushed), 32'(FRAME));
        check_eq("frame_uf", 32'(underflow), 32'd1);
        check_eq("frame_req_idle", 32'(mem_req), 32'd0);

        // Asynchronous reset mid-line
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, (i % 4) == 0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_req", 32'(mem_req), 32'd0);
        check_eq("arst_addr", 32'(mem_addr), 32'd0);
        check_eq("arst_rgb", 32'({r, g, b}), 32'd0);
        check_eq("arst_uf", 32'(underflow), 32'd0);
        q.delete();
        pushed      = 0;
        consumed    = 0;
        uf_m        = 1'b0;
        last_rgb    = '0;
        wait_cnt    = 0;
        mem_ack     = 1'b0;
        pix_en      = 1'b0;
        active      = 1'b0;
        frame_start = 1'b0;
        @(negedge clk_in);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_first_req", 32'(mem_req), 32'd1);
        for (int i = 0; i < 60; i++) cycle(1'b0, 1'b0, (i % 4) == 0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("restart_uf", 32'(underflow), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_pixel_fetch.md
VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 16, pixel prefetch depth, power of two, at least 4.
REQ-004 Parameter ADDR_W, default 19, memory address width, at least clog2(H_ACTIVE*V_ACTIVE).
REQ-005 clk_in  input  1  single system clock; all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 frame_start  input  1  one-cycle pulse from VGA timing at start of vertical blanking before frame.
REQ-008 pix_en  input  1  pixel-clock enable from VGA timing; one pixel consumed per asserted cycle.
REQ-009 active  input  1  high while timing is in the visible region; sampled only when pix_en=1.
REQ-010 mem_req  output  1  read request to pixel memory.
REQ-011 mem_addr  output  ADDR_W  linear pixel address, valid while mem_req=1.
REQ-012 mem_ack  input  1  one-cycle acknowledge; mem_data valid in the same cycle.
REQ-013 mem_data  input  24  pixel {r[7:0],g[7:0],b[7:0]}.
REQ-014 r, g, b  output  8 each  registered pixel colour to VGA output stage.
REQ-015 underflow  output  1  sticky flag: a visible pixel was needed while FIFO empty.

Function
REQ-016 Fetch FSM states: IDLE, REQ, and HOLD; the FSM shall change state only as stated in REQ-017 to REQ-020.
REQ-017 IDLE->REQ when the FIFO holds fewer than FIFO_DEPTH-1 entries and fetch address is below H_ACTIVE*V_ACTIVE.
REQ-018 REQ drives mem_req=1 with mem_addr=fetch address, holding both stable until mem_ack.
REQ-019 On mem_ack: write mem_data to FIFO, increment fetch address, go to HOLD.
REQ-020 HOLD->IDLE after one cycle; at most one request outstanding; max throughput one pixel per 3 cycles.
REQ-021 When pix_en=1 and active=1 with FIFO non-empty: pop one entry and register it to r,g,b the next cycle (latency 1 cycle from pop).
REQ-022 When pix_en=1 and active=1 with FIFO empty: drive r,g,b=0 next cycle and set underflow.
REQ-023 When pix_en=1 and active=0: drive r,g,b=0 next cycle; no pop.
REQ-024 When pix_en=0: r,g,b hold value; no pop.
REQ-025 Simultaneous push and pop in one cycle shall both take effect; count unchanged.
REQ-026 FIFO never overflows: no request issued at count >= FIFO_DEPTH-1, leaving one slot for an in-flight ack.
REQ-027 frame_start: flush FIFO, reset fetch address to 0, clear underflow, FSM to IDLE; mem_ack arriving that cycle is discarded.
REQ-028 frame_start while in REQ shall drop mem_req the next cycle; any late ack thereafter while in IDLE is ignored.
REQ-029 Fetch address saturates at H_ACTIVE*V_ACTIVE; no fetch beyond frame end until frame_start.
REQ-030 Active pixels consumed beyond the fetched frame count return black and set underflow.

Reset
REQ-031 rst_n=0 forces asynchronously: state IDLE, mem_req=0, mem_addr=0, FIFO empty, fetch address 0, r=g=b=0, underflow=0.
REQ-032 Reset deasserted mid-operation: block resumes from reset state; first fetch begins the cycle after rst_n rises.

Structure
REQ-033 Shared package vga_pkg holds the pixel struct (r,g,b bytes), fetch state enum, and default H_ACTIVE/V_ACTIVE constants.
REQ-034 FIFO implemented as one sub-module, pixel_fifo (sync, count output, push/pop/flush); fetch FSM and output register in top.

Verification
REQ-035 Reset then mem_ack one cycle after every request, no pix_en -> FIFO fills to FIFO_DEPTH-1 (15), mem_req stays 0, addresses 0..14 issued in order.
REQ-036 Memory returns data=address; pix_en every 4th cycle, active for 640 pixels/line -> r,g,b stream 0,1,2,... with no gaps; underflow stays 0.
REQ-037 mem_ack delayed 20 cycles, pix_en every cycle, active=1 -> r,g,b=0 on starved pixels, underflow=1 and holds until frame_start.
REQ-038 frame_start asserted while mem_req=1 at address 100 -> FIFO empty next cycle, mem_req drops, next request addresses 0, underflow cleared.
REQ-039 Full frame of 307200 active pixels then extra active pixels -> no request above address 307199, extra pixels black, underflow=1.
REQ-040 rst_n pulsed low asynchronously mid-line -> all outputs 0 within that cycle without a clock edge, fetch restarts at address 0.
